// File: rtl/mux_scan_pkg.sv
// Shared types and channel-search helpers for the 4:1 mux channel scanner.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } chan_sel_t;

  // Lowest enabled channel strictly above ch.
  function automatic chan_sel_t next_enabled(input logic [NUM_CH-1:0] mask,
                                             input logic [SEL_W-1:0]  ch);
    chan_sel_t r;
    r = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (mask[k] && (k > int'(ch))) begin
        r.found = 1'b1;
        r.idx   = SEL_W'(k);
      end
    end
    return r;
  endfunction

  function automatic chan_sel_t first_enabled(input logic [NUM_CH-1:0] mask);
    chan_sel_t r;
    r = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (mask[k]) begin
        r.found = 1'b1;
        r.idx   = SEL_W'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_dwell_ctr.sv
// Dwell counter with synchronous clear and terminal-count flag.
// With MUX_SCAN_MAJORITY_EN it also flags the two cycles preceding terminal count.
module mux_scan_dwell_ctr #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
`ifdef MUX_SCAN_MAJORITY_EN
  ,
  output logic pre2,
  output logic pre1
`endif
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(DWELL - 1));

`ifdef MUX_SCAN_MAJORITY_EN
  assign pre2 = (cnt_q == CNT_W'(DWELL - 3));
  assign pre1 = (cnt_q == CNT_W'(DWELL - 2));
`endif

endmodule

// File: rtl/mux_channel_scanner.sv
// Steps the 4:1 mux selects through the enabled channels, samples f after each dwell
// and publishes a double-buffered 4-bit frame. Optional MUX_SCAN_MAJORITY_EN: 2-of-3 vote.
module mux_channel_scanner
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                cont,
  input  logic [NUM_CH-1:0]   chan_en,
  input  logic                mux_f,
  output logic                s0,
  output logic                s1,
  output logic                busy,
  output logic                sample_valid,
  output logic [SEL_W-1:0]    sample_chan,
  output logic [NUM_CH-1:0]   frame,
  output logic                frame_valid
);

  if ((DWELL < 1) || (DWELL > 255)) begin : g_bad_dwell
    $error("mux_channel_scanner: DWELL must be in 1..255");
  end
  if ((2 ** CNT_W) <= DWELL) begin : g_bad_cnt_w
    $error("mux_channel_scanner: CNT_W too narrow for DWELL");
  end
`ifdef MUX_SCAN_MAJORITY_EN
  if (DWELL < 3) begin : g_bad_majority
    $error("mux_channel_scanner: majority sampling needs DWELL >= 3");
  end
`endif

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [NUM_CH-1:0]  work_q, work_d;
  logic [NUM_CH-1:0]  frame_q, frame_d;
  logic               frame_valid_q, frame_valid_d;
  logic               sample_valid_q, sample_valid_d;
  logic [SEL_W-1:0]   sample_chan_q, sample_chan_d;
  logic               busy_q, busy_d;

  logic               ctr_clr;
  logic               ctr_en;
  logic               dwell_tc;
  logic               sample_bit;

  chan_sel_t          nxt;
  chan_sel_t          first_in;
  chan_sel_t          first_lat;

  assign nxt       = next_enabled(mask_q, ch_q);
  assign first_in  = first_enabled(chan_en);
  assign first_lat = first_enabled(mask_q);

`ifdef MUX_SCAN_MAJORITY_EN
  logic dwell_pre2;
  logic dwell_pre1;
  logic samp0_q, samp0_d;
  logic samp1_q, samp1_d;

  mux_scan_dwell_ctr #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .tc    (dwell_tc),
    .pre2  (dwell_pre2),
    .pre1  (dwell_pre1)
  );

  // The first two votes are held in flops; the third is the live f at terminal count.
  always_comb begin
    samp0_d = samp0_q;
    samp1_d = samp1_q;
    if (state_q == ST_SCAN) begin
      if (dwell_pre2) samp0_d = mux_f;
      if (dwell_pre1) samp1_d = mux_f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp0_q <= 1'b0;
      samp1_q <= 1'b0;
    end else begin
      samp0_q <= samp0_d;
      samp1_q <= samp1_d;
    end
  end

  assign sample_bit = (samp0_q & samp1_q) | (samp0_q & mux_f) | (samp1_q & mux_f);
`else
  mux_scan_dwell_ctr #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .tc    (dwell_tc)
  );

  assign sample_bit = mux_f;
`endif

  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    mask_d         = mask_q;
    work_d         = work_q;
    frame_d        = frame_q;
    frame_valid_d  = 1'b0;
    sample_valid_d = 1'b0;
    sample_chan_d  = sample_chan_q;
    ctr_clr        = 1'b1;
    ctr_en         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Abort outranks start even when idle.
        if (start && !abort && first_in.found) begin
          mask_d  = chan_en;
          ch_d    = first_in.idx;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          ctr_en  = 1'b1;
          ctr_clr = dwell_tc;
          if (dwell_tc) begin
            work_d[ch_q]   = sample_bit;
            sample_valid_d = 1'b1;
            sample_chan_d  = ch_q;
            if (nxt.found) begin
              ch_d = nxt.idx;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          frame_d       = work_q;
          frame_valid_d = 1'b1;
          if (cont && first_lat.found) begin
            ch_d    = first_lat.idx;
            state_d = ST_SCAN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      ch_q           <= '0;
      mask_q         <= '0;
      work_q         <= '0;
      frame_q        <= '0;
      frame_valid_q  <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_chan_q  <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      mask_q         <= mask_d;
      work_q         <= work_d;
      frame_q        <= frame_d;
      frame_valid_q  <= frame_valid_d;
      sample_valid_q <= sample_valid_d;
      sample_chan_q  <= sample_chan_d;
      busy_q         <= busy_d;
    end
  end

  assign s0           = ch_q[0];
  assign s1           = ch_q[1];
  assign busy         = busy_q;
  assign sample_valid = sample_valid_q;
  assign sample_chan  = sample_chan_q;
  assign frame        = frame_q;
  assign frame_valid  = frame_valid_q;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Bench for mux_channel_scanner: timeline model + per-cycle compare, plus directed literal checks.
module tb_mux_channel_scanner;

  localparam int DWELL = 4;
  localparam int CNT_W = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cont = 1'b0;
  logic [3:0] chan_en = 4'h0;
  logic [3:0] pat = 4'h0;
  logic       glitch = 1'b0;
  logic       mux_f;
  logic       s0, s1, busy, sample_valid, frame_valid;
  logic [1:0] sample_chan;
  logic [3:0] frame;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign mux_f = pat[{s1, s0}] ^ glitch;

  mux_channel_scanner #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .cont         (cont),
    .chan_en      (chan_en),
    .mux_f        (mux_f),
    .s0           (s0),
    .s1           (s1),
    .busy         (busy),
    .sample_valid (sample_valid),
    .sample_chan  (sample_chan),
    .frame        (frame),
    .frame_valid  (frame_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model + scoreboard ----------------
  // Output vector layout: {s1,s0,busy,sample_valid,sample_chan[1:0],frame[3:0],frame_valid}
  logic [10:0] exp_q[$];
  bit          m_busy = 1'b0;
  int          m_t = 0;
  int          m_list[$];
  logic [1:0]  m_sel = 2'd0;
  logic [1:0]  m_sch = 2'd0;
  logic        m_sv = 1'b0;
  logic        m_fv = 1'b0;
  logic [3:0]  m_work = 4'h0;
  logic [3:0]  m_frame = 4'h0;
  bit          m_win[256];

  function automatic logic [10:0] model_vec();
    return {m_sel, m_busy, m_sv, m_sch, m_frame, m_fv};
  endfunction

  // Inputs are stable at the falling edge, so this step predicts the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_t = 0; m_sel = 2'd0; m_sch = 2'd0;
      m_sv = 1'b0; m_fv = 1'b0; m_work = 4'h0; m_frame = 4'h0;
      exp_q.delete();
      exp_q.push_back(model_vec());
    end else begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        check("cycle_outputs", {s1, s0, busy, sample_valid, sample_chan, frame, frame_valid},
              exp_q.pop_front());
      end
      m_sv = 1'b0;
      m_fv = 1'b0;
      if (!m_busy) begin
        if (start && !abort && chan_en != 4'h0) begin
          m_list.delete();
          for (int k = 0; k < 4; k++) if (chan_en[k]) m_list.push_back(k);
          m_busy = 1'b1;
          m_t = 0;
          m_sel = 2'(m_list[0]);
        end
      end else if (abort) begin
        m_busy = 1'b0;
      end else begin
        int e;
        int m;
        e = m_t + 1;
        m = m_list.size();
        if (e <= m * DWELL) begin
          m_win[(e - 1) % DWELL] = mux_f;
          if (e % DWELL == 0) begin
            logic b;
            int   c;
`ifdef MUX_SCAN_MAJORITY_EN
            b = (int'(m_win[DWELL-3]) + int'(m_win[DWELL-2]) + int'(m_win[DWELL-1])) >= 2;
`else
            b = mux_f;
`endif
            c = m_list[e / DWELL - 1];
            m_work[c] = b;
            m_sv = 1'b1;
            m_sch = 2'(c);
            if (e < m * DWELL) m_sel = 2'(m_list[e / DWELL]);
          end
          m_t = e;
        end else begin
          m_frame = m_work;
          m_fv = 1'b1;
          m_t = 0;
          if (cont) m_sel = 2'(m_list[0]);
          else m_busy = 1'b0;
        end
      end
      exp_q.push_back(model_vec());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [3:0] m, output int acc);
    @(posedge clk); #2;
    start = 1'b1;
    chan_en = m;
    @(posedge clk); #2;
    acc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_frame(input int acc, output int dt);
    int k;
    dt = -1;
    k = 0;
    while (dt < 0 && k < 200) begin
      @(posedge clk); #1;
      if (frame_valid) dt = cyc - acc;
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int acc;
    int dt;
    int k;
    int nfv;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {s1, s0, busy, sample_valid, sample_chan, frame, frame_valid}, 11'd0);
    #1 rst_n = 1'b1;

    // start with empty mask is ignored
    do_start(4'h0, acc);
    check("empty_mask_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    check("empty_mask_busy_later", busy, 1'b0);

    // Full scan, pattern 1,0,1,1 on ch0..3; selects step every DWELL cycles
    pat = 4'b1101;
    do_start(4'hf, acc);
    for (int j = 0; j < 4; j++) begin
      check("sel_step", {s1, s0}, j);
      repeat (DWELL) @(posedge clk);
      #2;
    end
    wait_frame(acc, dt);
    check("full_fv_latency", dt, 17);
    check("full_frame", frame, 4'b1101);
    @(posedge clk); #1;
    check("full_fv_one_cycle", frame_valid, 1'b0);

    // start while busy is ignored (no restart, mask unchanged)
    pat = 4'b0101;
    do_start(4'hf, acc);
    repeat (5) @(posedge clk);
    #2;
    start = 1'b1;
    chan_en = 4'b0010;
    @(posedge clk); #2;
    start = 1'b0;
    wait_frame(acc, dt);
    check("busy_start_latency", dt, 17);
    check("busy_start_frame", frame, 4'b0101);

    // Sparse mask keeps stale bits of disabled channels
    pat = 4'b1111;
    do_start(4'b1010, acc);
    wait_frame(acc, dt);
    check("sparse_fv_latency", dt, 9);
    check("sparse_frame", frame, 4'b1111);

    // Abort during ch2
    pat = 4'b0000;
    do_start(4'hf, acc);
    k = 0;
    while ({s1, s0} != 2'd2 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("abort_reached_ch2", {s1, s0}, 2'd2);
    #1 abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_frame_kept", frame, 4'b1111);
    check("abort_sel_hold", {s1, s0}, 2'd2);
    nfv = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (frame_valid) nfv++;
    end
    check("abort_no_fv", nfv, 0);
    pat = 4'b0110;
    do_start(4'hf, acc);
    wait_frame(acc, dt);
    check("post_abort_latency", dt, 17);
    check("post_abort_frame", frame, 4'b0110);

    // Continuous mode on ch0 only; chan_en change mid-run has no effect
    pat = 4'b0001;
    cont = 1'b1;
    do_start(4'b0001, acc);
    wait_frame(acc, dt);
    check("cont_first_latency", dt, DWELL + 1);
    check("cont_frame_1", frame, 4'b0111);
    acc = cyc;
    wait_frame(acc, dt);
    check("cont_period_1", dt, DWELL + 1);
    #1 chan_en = 4'hf;
    acc = cyc;
    wait_frame(acc, dt);
    check("cont_period_2", dt, DWELL + 1);
    check("cont_frame_2", frame, 4'b0111);
    #1 cont = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    check("cont_stop_idle", busy, 1'b0);

    // Reset mid-scan clears everything asynchronously
    pat = 4'b1111;
    do_start(4'hf, acc);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {s1, s0, busy, sample_valid, sample_chan, frame, frame_valid}, 11'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_reset_idle", busy, 1'b0);

    // Glitch on f while ch1 is selected
    pat = 4'b1111;
    do_start(4'hf, acc);
`ifdef MUX_SCAN_MAJORITY_EN
    repeat (6) @(posedge clk);
`else
    repeat (7) @(posedge clk);
`endif
    #2 glitch = 1'b1;
    @(posedge clk); #2;
    glitch = 1'b0;
    wait_frame(acc, dt);
    check("glitch_latency", dt, 17);
`ifdef MUX_SCAN_MAJORITY_EN
    check("glitch_frame", frame, 4'b1111);
`else
    check("glitch_frame", frame, 4'b1101);
`endif

    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
